// File: rtl/apb_master_arbiter.sv
//==============================================================================
// Module  : apb_master_arbiter
// Brief   : Round-robin arbiter sharing one APB master control port between
//           N_REQ requesters. Optional burst lock enabled by `define ARB_LOCK_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_master_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_rw,
    input  logic [N_REQ*12-1:0]   req_addr,
    input  logic [N_REQ*32-1:0]   req_wdata,
    input  logic [N_REQ-1:0]      req_lock,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [PTR_W-1:0]      gnt_id,
    output logic                  arb_busy,
    output logic                  m_start,
    output logic                  m_rw,
    output logic [11:0]           m_addr,
    output logic [31:0]           m_wdata,
    input  logic [31:0]           m_rdata,
    input  logic                  m_idle,
    input  logic                  m_busy
);

    localparam int c_AW = 12;
    localparam int c_DW = 32;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_last_gnt, w_last_gnt_nxt;
    logic [PTR_W-1:0]   r_gnt_id, w_gnt_id_nxt;
    logic [N_REQ-1:0]   r_req_ready, w_req_ready_nxt;
    logic [N_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
    logic [c_DW-1:0]    r_rsp_rdata, w_rsp_rdata_nxt;
    logic               r_m_start, w_m_start_nxt;
    logic               r_m_rw, w_m_rw_nxt;
    logic [c_AW-1:0]    r_m_addr, w_m_addr_nxt;
    logic [c_DW-1:0]    r_m_wdata, w_m_wdata_nxt;

    logic [PTR_W-1:0]   w_rr_win;
    logic [PTR_W-1:0]   w_idx;
    logic               w_rr_found;
    logic [PTR_W-1:0]   w_win;
    logic               w_grant;

    // m_busy is only meaningful to observers; the handshake relies on m_idle.
    logic               w_unused_busy;
    assign w_unused_busy = m_busy;

    // First valid requester strictly after the previous owner, with wrap.
    always_comb begin
        w_rr_win   = '0;
        w_rr_found = 1'b0;
        w_idx      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PTR_W'((int'(r_last_gnt) + k) % N_REQ);
            if (!w_rr_found && req_valid[w_idx]) begin
                w_rr_win   = w_idx;
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_grant = (r_state == ST_ARB) && m_idle && (|req_valid);

`ifdef ARB_LOCK_EN
    logic r_lock_hold;

    // A locked owner keeps the port while it stays valid; otherwise the
    // round-robin search continues from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_hold <= 1'b0;
        end else if (w_grant) begin
            r_lock_hold <= req_lock[w_win];
        end
    end

    assign w_win = (r_lock_hold && req_valid[r_last_gnt]) ? r_last_gnt : w_rr_win;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;
    assign w_win         = w_rr_win;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_last_gnt_nxt  = r_last_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_m_start_nxt   = 1'b0;
        w_m_rw_nxt      = r_m_rw;
        w_m_addr_nxt    = r_m_addr;
        w_m_wdata_nxt   = r_m_wdata;
        case (r_state)
            ST_ARB: begin
                if (w_grant) begin
                    w_m_rw_nxt             = req_rw[w_win];
                    w_m_addr_nxt           = req_addr[w_win*c_AW +: c_AW];
                    w_m_wdata_nxt          = req_wdata[w_win*c_DW +: c_DW];
                    w_gnt_id_nxt           = w_win;
                    w_req_ready_nxt[w_win] = 1'b1;
                    w_m_start_nxt          = 1'b1;
                    w_state_nxt            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_last_gnt_nxt = r_gnt_id;
                w_state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_idle) begin
                    w_rsp_valid_nxt[r_gnt_id] = 1'b1;
                    w_rsp_rdata_nxt           = r_m_rw ? '0 : m_rdata;
                    w_state_nxt               = ST_ARB;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ARB;
            r_last_gnt  <= PTR_W'(N_REQ - 1);
            r_gnt_id    <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_m_start   <= 1'b0;
            r_m_rw      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_gnt  <= w_last_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_m_start   <= w_m_start_nxt;
            r_m_rw      <= w_m_rw_nxt;
            r_m_addr    <= w_m_addr_nxt;
            r_m_wdata   <= w_m_wdata_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign gnt_id    = r_gnt_id;
    assign arb_busy  = (r_state != ST_ARB);
    assign m_start   = r_m_start;
    assign m_rw      = r_m_rw;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;

endmodule

`default_nettype wire

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin arbiter that shares the single-transaction APB master control port (start/rw/addr/wdata/rdata/idle/busy) between N_REQ requesters: the QSPI command engine, the DMA descriptor fetcher and the CSR bridge. It accepts one request at a time and converts it into a single-cycle start pulse. It tracks the master's busy/idle handshake and returns read data with a per-requester completion pulse. It sits directly upstream of the APB master and owns its control inputs exclusively.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- PTR_W, $clog2(N_REQ), grant index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  request pending, held until req_ready seen
- req_rw  in  N_REQ  per-requester 0=read, 1=write
- req_addr  in  N_REQ*12  packed addresses, requester i at [12i+11:12i]
- req_wdata  in  N_REQ*32  packed write data, requester i at [32i+31:32i]
- req_lock  in  N_REQ  keep grant for next transfer (ARB_LOCK_EN only)
- req_ready  out  N_REQ  one-cycle accept pulse to winner
- rsp_valid  out  N_REQ  one-cycle completion pulse to owner
- rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes
- gnt_id  out  PTR_W  index of current/last owner
- arb_busy  out  1  transfer in flight (state != ARB)
- m_start  out  1  to master start
- m_rw  out  1  to master rw
- m_addr  out  12  to master addr
- m_wdata  out  32  to master wdata
- m_rdata  in  32  from master rdata
- m_idle  in  1  from master idle
- m_busy  in  1  from master busy

## Operation
- States: ARB, ISSUE, WAIT.
- ARB behaviour:
  - Arbitration happens when m_idle=1 and |req_valid.
  - The winner is the first valid index searching upward (with wrap) from last_gnt+1.
  - On that edge, the arbiter latches the winner's rw/addr/wdata into m_rw/m_addr/m_wdata and sets gnt_id.
  - It registers req_ready[win]=1 and m_start=1, then moves to ISSUE.
- ISSUE behaviour:
  - Lasts exactly one cycle, with m_start=1 and req_ready[win]=1.
  - The next edge clears both, updates last_gnt to the winner and moves to WAIT.
- WAIT behaviour:
  - The arbiter holds m_rw/m_addr/m_wdata stable.
  - On the first cycle with m_idle=1, it registers rsp_valid[gnt_id]=1 and sets rsp_rdata to m_rdata for a read or 0 for a write, then returns to ARB.
  - It ignores m_busy apart from the arb_busy consistency check in the bench.
- Requester rules:
  - The requester holds valid and its fields stable until it sees req_ready.
  - It drops valid on the cycle after req_ready unless it has another request.
  - Fields are sampled only on the ARB grant edge.
- Only one rsp_valid and one req_ready bit are ever high, and never in the same cycle.
- last_gnt resets to N_REQ-1, so requester 0 wins first.
- If req_valid drops in ARB before a grant, no transfer occurs. There is no latching of pending requests.
- If m_idle=0 in ARB (external owner), the arbiter waits with no grant.
- Reset mid-transfer: the arbiter returns to ARB immediately, with no rsp_valid for the aborted transfer. The master shares the same rst_n.

## Timing
- Reset values:
  - All outputs 0, including req_ready, rsp_valid, rsp_rdata, gnt_id=0, arb_busy, m_start, m_rw, m_addr, m_wdata.
  - State ARB; last_gnt=N_REQ-1.
- With zero-wait pready, for a grant edge at end of cycle 0:
  - Cycle 1: ISSUE with m_start=1.
  - Cycles 2–3: master SETUP/ACCESS.
  - Cycle 4: m_idle=1.
  - Cycle 5: rsp_valid=1 and the arbiter is back in ARB.
- Request-to-response latency is 5 cycles plus pready wait states.
- A new grant can occur at the end of cycle 5, so m_start is next high in cycle 6.
- m_start is low for at least 4 cycles between pulses, so the master's rising-edge detector always fires.
- m_start is never high for more than one cycle.

## Configuration
- ARB_LOCK_EN defined:
  - If req_lock[win] was 1 at the grant edge, the next ARB cycle grants the same requester when its req_valid=1 (bursts).
  - If that requester is not valid, normal round-robin resumes from it.
  - Lock cannot starve others indefinitely only by requester discipline; no timeout.
- ARB_LOCK_EN undefined:
  - req_lock is ignored and arbitration is pure round-robin.

## Test plan
- Single read, req 2, addr 0x010, slave returns 0xDEADBEEF, pready=1:
  - One m_start pulse in cycle 1 with m_addr=0x010 and m_rw=0.
  - rsp_valid[2] with rsp_rdata=0xDEADBEEF in cycle 5.
- All four requesters valid continuously with writes (wdata = 0x1000+i):
  - Grants in order 0,1,2,3,0 with m_wdata matching each grant.
  - Exactly one rsp_valid per grant, each with rsp_rdata=0.
- Slave inserts 3 pready wait states on a read from req 1:
  - rsp_valid[1] arrives in cycle 8.
  - m_addr/m_rw stay stable throughout.
  - m_start stays low after cycle 1.
- Reset asserted in WAIT:
  - All outputs go to 0 asynchronously and no rsp_valid appears.
  - After release, the first grant goes to requester 0.
- ARB_LOCK_EN, req 1 with req_lock=1 and req 0/3 valid, three back-to-back requests:
  - Grants 1,1,1 while lock is held.
  - Once lock drops, the next grant is 3, then 0.
- m_idle forced 0 in ARB with req_valid=1:
  - No req_ready and no m_start.
  - Grant occurs one edge after m_idle rises.
